mac_dot_mmio: RTL and testbench
===============================

# mac_dot_mmio

Parametrised multiply-accumulate engine behind an MMIO register front end. It computes the dot product of two LANES-element unsigned vectors plus a starting value. The starting value is either a host-supplied bias or the block's own previous result, which allows accumulation across transactions. It processes one lane per cycle through a single multiplier, supports wrap or saturating overflow handling, and uses a valid/ready handshake on both input and output sides.

## Interface
- WIDTH, 16, bit width of each vector element (unsigned)
- LANES, 4, number of elements per vector; must be >= 1
- ACC_WIDTH, 40, accumulator/result width; must be >= 2*WIDTH
- SATURATE, 0, 0 = wrap modulo 2^ACC_WIDTH, 1 = clamp to all-ones
- clock  input  1  clock; all state updates on rising edge
- reset  input  1  reset, synchronous, active-high
- input_ready  output  1  high only in IDLE
- input_valid  input  1  request to start a transaction
- a  input  LANES*WIDTH  vector A; lane i at bits [i*WIDTH +: WIDTH]
- b  input  LANES*WIDTH  vector B; same packing as a
- prev  input  ACC_WIDTH  starting value when acc_mode=0
- acc_mode  input  1  1 = start from current result register, ignore prev
- output_ready  input  1  consumer accepts result
- output_valid  output  1  high only in DONE
- result  output  ACC_WIDTH  registered result
- overflow  output  1  registered; set if this transaction overflowed
- busy  output  1  high whenever state != IDLE

## Operation
- States: IDLE, RUN, DONE. Encoding is free; there is no other state.
- IDLE:
  - On input_valid & input_ready, capture a and b into internal registers.
  - acc <= acc_mode ? result : prev.
  - lane counter <= 0; internal overflow flag <= 0.
  - Go to RUN.
- RUN, each cycle:
  - prod = a[cnt] * b[cnt], full 2*WIDTH bits, zero-extended to ACC_WIDTH.
  - sum = acc + prod, computed in ACC_WIDTH+1 bits; carry out means overflow.
  - SATURATE=0: acc <= sum mod 2^ACC_WIDTH; overflow flag set sticky.
  - SATURATE=1: on overflow, acc <= all-ones and the flag is set. Later lanes keep acc at all-ones.
  - cnt increments each cycle. On cnt == LANES-1, result <= final acc, overflow <= flag, go to DONE.
- DONE:
  - output_valid=1; result and overflow are held stable.
  - On output_ready, go to IDLE. Otherwise stay.
- result and overflow change only on RUN-to-DONE or on reset. They are held across IDLE, which is what acc_mode chaining relies on.
- Captured a, b and acc_mode are used. Changes on the input ports after acceptance have no effect.
- input_valid outside IDLE is ignored; nothing is queued.

## Timing
- Reset values: state IDLE, input_ready=1, busy=0, output_valid=0, result=0, overflow=0, counter=0.
- Latency:
  - Input handshake in cycle T.
  - RUN occupies cycles T+1 .. T+LANES.
  - output_valid first high in cycle T+LANES+1.
- LANES=1: exactly one RUN cycle.
- Output handshake in cycle U gives IDLE in U+1. The next input can be accepted in U+1 at the earliest, so minimum transaction period is LANES+2 cycles.
- output_ready high in the first DONE cycle is accepted that cycle.
- output_ready in IDLE or RUN is ignored.
- Reset in any state takes priority:
  - Next cycle is IDLE with all reset values, result=0.
  - Any in-flight transaction is discarded and no output_valid is produced.
- acc_mode=1 after reset starts from 0.
- Counter width is max(1, clog2(LANES)).

## Test plan
- Reset, then idle 3 cycles -> input_ready=1, busy=0, output_valid=0, result=0, overflow=0.
- LANES=4, a={1,2,3,4}, b={5,6,7,8}, prev=10, acc_mode=0 -> result=80, overflow=0, output_valid exactly 5 cycles after accept.
- Chaining: repeat the previous vectors with acc_mode=1 and prev=999 -> result=150 (prev ignored).
- Overflow with ACC_WIDTH=32, WIDTH=16, prev=0xFFFFFFF0, a lane0=0x10, b lane0=1, other lanes 0:
  - SATURATE=0 -> result=0x00000000, overflow=1.
  - SATURATE=1 -> result=0xFFFFFFFF, overflow=1.
- Backpressure: hold output_ready low for 10 DONE cycles while pulsing input_valid and changing a/b/prev -> output_valid stays high, result unchanged, no new transaction. Release output_ready -> IDLE next cycle.
- Reset asserted in the 2nd RUN cycle -> IDLE next cycle, result=0, output_valid never asserted. A following transaction computes correctly.

Source files
------------

// File: rtl/mac_dot_mmio.sv
// Dot-product MAC engine: one lane per cycle through a single multiplier.
// Starting value is either the host bias (prev) or the previous result, so results can be chained.
module mac_dot_mmio #(
  parameter int WIDTH     = 16,
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 40,
  parameter int SATURATE  = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   input_ready,
  input  logic                   input_valid,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic [ACC_WIDTH-1:0]   prev,
  input  logic                   acc_mode,
  input  logic                   output_ready,
  output logic                   output_valid,
  output logic [ACC_WIDTH-1:0]   result,
  output logic                   overflow,
  output logic                   busy
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LANES*WIDTH-1:0] a_q, a_d;
  logic [LANES*WIDTH-1:0] b_q, b_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   flag_q, flag_d;
  logic [ACC_WIDTH-1:0]   result_q, result_d;
  logic                   overflow_q, overflow_d;

  logic [WIDTH-1:0]       lane_a [LANES];
  logic [WIDTH-1:0]       lane_b [LANES];
  logic [2*WIDTH-1:0]     prod;
  logic [ACC_WIDTH:0]     sum;
  logic                   carry;
  logic [ACC_WIDTH-1:0]   acc_step;
  logic                   last_lane;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_a[gi] = a_q[gi*WIDTH +: WIDTH];
    assign lane_b[gi] = b_q[gi*WIDTH +: WIDTH];
  end

  // Carry out of the extra sum bit is the overflow indication.
  assign prod      = lane_a[cnt_q] * lane_b[cnt_q];
  assign sum       = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - 2*WIDTH){1'b0}}, prod};
  assign carry     = sum[ACC_WIDTH];
  assign acc_step  = (carry && (SATURATE != 0)) ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
  assign last_lane = (cnt_q == CNT_W'(LANES - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    flag_d     = flag_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (input_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = acc_mode ? result_q : prev;
          cnt_d   = '0;
          flag_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d  = acc_step;
        flag_d = flag_q | carry;
        cnt_d  = cnt_q + 1'b1;
        if (last_lane) begin
          result_d   = acc_step;
          overflow_d = flag_q | carry;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (output_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      flag_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      flag_q     <= flag_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign input_ready  = (state_q == S_IDLE);
  assign output_valid = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign result       = result_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_mac_dot_mmio.sv
// Scoreboard bench: a 40-bit wrap instance for the main flow and two 32-bit
// instances (wrap and saturate) for overflow handling.
module tb_mac_dot_mmio;

  localparam int L = 4;
  localparam int W = 16;

  logic        clock;
  logic        reset;
  logic [63:0] a_s, b_s;
  logic [39:0] prev_m;
  logic [31:0] prev_o;
  logic        acc_mode_s;
  logic        out_ready;
  logic        valid_m, valid_o;

  logic        in_ready_m, out_valid_m, ovf_m, busy_m;
  logic [39:0] result_m;
  logic        in_ready_w, out_valid_w, ovf_w, busy_w;
  logic [31:0] result_w;
  logic        in_ready_s, out_valid_s, ovf_s, busy_s;
  logic [31:0] result_s;

  int checks = 0;
  int errors = 0;

  logic [64:0] q_m[$];
  logic [64:0] q_w[$];
  logic [64:0] q_s[$];
  logic [63:0] last_m = '0, last_w = '0, last_s = '0;

  mac_dot_mmio #(.WIDTH(W), .LANES(L), .ACC_WIDTH(40), .SATURATE(0)) u_dut (
    .clock(clock), .reset(reset), .input_ready(in_ready_m), .input_valid(valid_m),
    .a(a_s), .b(b_s), .prev(prev_m), .acc_mode(acc_mode_s), .output_ready(out_ready),
    .output_valid(out_valid_m), .result(result_m), .overflow(ovf_m), .busy(busy_m)
  );

  mac_dot_mmio #(.WIDTH(W), .LANES(L), .ACC_WIDTH(32), .SATURATE(0)) u_wrap (
    .clock(clock), .reset(reset), .input_ready(in_ready_w), .input_valid(valid_o),
    .a(a_s), .b(b_s), .prev(prev_o), .acc_mode(acc_mode_s), .output_ready(out_ready),
    .output_valid(out_valid_w), .result(result_w), .overflow(ovf_w), .busy(busy_w)
  );

  mac_dot_mmio #(.WIDTH(W), .LANES(L), .ACC_WIDTH(32), .SATURATE(1)) u_sat (
    .clock(clock), .reset(reset), .input_ready(in_ready_s), .input_valid(valid_o),
    .a(a_s), .b(b_s), .prev(prev_o), .acc_mode(acc_mode_s), .output_ready(out_ready),
    .output_valid(out_valid_s), .result(result_s), .overflow(ovf_s), .busy(busy_s)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference dot product: {overflow, result} for a given accumulator width.
  function automatic logic [64:0] model(input logic [63:0] av, input logic [63:0] bv,
                                        input logic [63:0] start, input int accw, input bit sat);
    logic [63:0] mask, acc, p, sum;
    bit flag;
    mask = (64'd1 << accw) - 64'd1;
    acc  = start & mask;
    flag = 1'b0;
    for (int i = 0; i < L; i++) begin
      p   = 64'(av[i*W +: W]) * 64'(bv[i*W +: W]);
      sum = acc + p;
      if (sum > mask) begin
        flag = 1'b1;
        acc  = sat ? mask : (sum & mask);
      end else begin
        acc = sum;
      end
    end
    return {flag, acc};
  endfunction

  // sel 0 drives the 40-bit instance, sel 1 drives both 32-bit instances.
  task automatic send(input int sel, input logic [63:0] av, input logic [63:0] bv,
                      input logic [63:0] pv, input bit mode);
    logic [64:0] e;
    bit ok;
    int n;
    @(posedge clock); #1;
    a_s = av; b_s = bv; prev_m = pv[39:0]; prev_o = pv[31:0]; acc_mode_s = mode;
    if (sel == 0) valid_m = 1'b1; else valid_o = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 40) begin
      @(negedge clock);
      n++;
      if ((sel == 0) ? in_ready_m : (in_ready_w && in_ready_s)) ok = 1'b1;
      else @(posedge clock);
    end
    if (!ok) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else if (sel == 0) begin
      e = model(av, bv, mode ? last_m : {24'd0, pv[39:0]}, 40, 1'b0);
      last_m = e[63:0];
      q_m.push_back(e);
    end else begin
      e = model(av, bv, mode ? last_w : {32'd0, pv[31:0]}, 32, 1'b0);
      last_w = e[63:0];
      q_w.push_back(e);
      e = model(av, bv, mode ? last_s : {32'd0, pv[31:0]}, 32, 1'b1);
      last_s = e[63:0];
      q_s.push_back(e);
    end
    @(posedge clock); #1;
    valid_m = 1'b0;
    valid_o = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_m.size() + q_w.size() + q_s.size()) != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("drain_timeout", 64'd0, 64'd1);
    @(posedge clock); #1;
  endtask

  always @(negedge clock) begin : mon_m
    logic [64:0] e;
    if (!reset && out_valid_m) begin
      if (q_m.size() == 0) check("m_spurious_valid", 64'd1, 64'd0);
      else if (out_ready) begin
        e = q_m.pop_front();
        check("m_result", 64'(result_m), e[63:0]);
        check("m_overflow", 64'(ovf_m), 64'(e[64]));
        $display("txn m   result=%0h overflow=%0b", result_m, ovf_m);
      end
    end
  end

  always @(negedge clock) begin : mon_w
    logic [64:0] e;
    if (!reset && out_valid_w) begin
      if (q_w.size() == 0) check("w_spurious_valid", 64'd1, 64'd0);
      else if (out_ready) begin
        e = q_w.pop_front();
        check("w_result", 64'(result_w), e[63:0]);
        check("w_overflow", 64'(ovf_w), 64'(e[64]));
        $display("txn wrap result=%0h overflow=%0b", result_w, ovf_w);
      end
    end
  end

  always @(negedge clock) begin : mon_s
    logic [64:0] e;
    if (!reset && out_valid_s) begin
      if (q_s.size() == 0) check("s_spurious_valid", 64'd1, 64'd0);
      else if (out_ready) begin
        e = q_s.pop_front();
        check("s_result", 64'(result_s), e[63:0]);
        check("s_overflow", 64'(ovf_s), 64'(e[64]));
        $display("txn sat  result=%0h overflow=%0b", result_s, ovf_s);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] held;
    int n;
    clock = 1'b0; reset = 1'b1;
    a_s = '0; b_s = '0; prev_m = '0; prev_o = '0; acc_mode_s = 1'b0;
    out_ready = 1'b0; valid_m = 1'b0; valid_o = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_input_ready", 64'(in_ready_m), 64'd1);
    check("rst_busy", 64'(busy_m), 64'd0);
    check("rst_output_valid", 64'(out_valid_m), 64'd0);
    check("rst_result", 64'(result_m), 64'd0);
    check("rst_overflow", 64'(ovf_m), 64'd0);
    check("rst_result_w", 64'(result_w), 64'd0);

    // Basic dot product with bias, plus latency measurement.
    out_ready = 1'b1;
    send(0, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 64'd10, 1'b0);
    n = 0;
    while (n < 50) begin
      @(negedge clock);
      n++;
      if (out_valid_m) break;
    end
    check("latency", 64'(n), 64'(L + 1));
    check("basic_result", 64'(result_m), 64'd80);
    wait_idle();

    // Chaining: prev must be ignored.
    send(0, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 64'd999, 1'b1);
    wait_idle();
    check("chain_result", 64'(result_m), 64'd150);

    // 32-bit overflow: wrap vs saturate.
    send(1, 64'h0000_0000_0000_0010, 64'h0000_0000_0000_0001, 64'hFFFF_FFF0, 1'b0);
    wait_idle();
    check("wrap_result", 64'(result_w), 64'h0);
    check("wrap_overflow", 64'(ovf_w), 64'd1);
    check("sat_result", 64'(result_s), 64'hFFFF_FFFF);
    check("sat_overflow", 64'(ovf_s), 64'd1);
    send(1, 64'h0000_0003_0000_0010, 64'h0000_0002_0000_0001, 64'hFFFF_FFF0, 1'b0);
    wait_idle();
    send(1, 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 64'd0, 1'b1);
    wait_idle();

    // Random mix with chaining and large biases on the 40-bit instance.
    for (int i = 0; i < 8; i++) begin
      send(0, {$urandom(), $urandom()}, {$urandom(), $urandom()},
           {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
      wait_idle();
    end

    // Backpressure: result held, extra requests ignored.
    out_ready = 1'b0;
    send(0, 64'h0010_0020_0030_0040, 64'h0001_0002_0003_0004, 64'd7, 1'b0);
    n = 0;
    while (!out_valid_m && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("bp_valid_seen", 64'(out_valid_m), 64'd1);
    held = result_m;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      valid_m = ~valid_m;
      a_s = {$urandom(), $urandom()};
      b_s = {$urandom(), $urandom()};
      prev_m = 40'($urandom());
      @(negedge clock);
      check("bp_valid", 64'(out_valid_m), 64'd1);
      check("bp_result", 64'(result_m), 64'(held));
      check("bp_input_ready", 64'(in_ready_m), 64'd0);
    end
    @(posedge clock); #1;
    valid_m = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("bp_release_ready", 64'(in_ready_m), 64'd1);
    check("bp_release_busy", 64'(busy_m), 64'd0);
    check("bp_release_valid", 64'(out_valid_m), 64'd0);
    wait_idle();

    // Reset during the second RUN cycle discards the transaction.
    send(0, 64'h0005_0005_0005_0005, 64'h0005_0005_0005_0005, 64'd5, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    q_m.delete();
    last_m = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("midrst_input_ready", 64'(in_ready_m), 64'd1);
    check("midrst_busy", 64'(busy_m), 64'd0);
    check("midrst_result", 64'(result_m), 64'd0);
    check("midrst_overflow", 64'(ovf_m), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("midrst_no_valid", 64'(out_valid_m), 64'd0);
    end
    send(0, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 64'd777, 1'b1);
    wait_idle();
    check("post_rst_chain", 64'(result_m), 64'd70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
